// File: rtl/axil_wb_pkg.sv
// axil_wb_pkg: shared state encoding and AXI response codes for the AXI4-Lite to Wishbone bridge.
package axil_wb_pkg;
  typedef enum logic [2:0] {
    IDLE,
    WR_COLLECT,
    WB_WRITE,
    WB_READ,
    B_RESP,
    R_RESP
  } axil_wb_state_t;
  localparam logic [1:0] AXI_RESP_OKAY = 2'b00;
  localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
endpackage

// File: rtl/axil_wb_bridge.sv
// axil_wb_bridge: AXI4-Lite slave to Wishbone classic master, one transaction in flight, with ack timeout.
module axil_wb_bridge
  import axil_wb_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    awvalid,
  output logic                    awready,
  input  logic [ADDR_WIDTH-1:0]   awaddr,
  input  logic [2:0]              awprot,
  input  logic                    wvalid,
  output logic                    wready,
  input  logic [DATA_WIDTH-1:0]   wdata,
  input  logic [DATA_WIDTH/8-1:0] wstrb,
  output logic                    bvalid,
  input  logic                    bready,
  output logic [1:0]              bresp,
  input  logic                    arvalid,
  output logic                    arready,
  input  logic [ADDR_WIDTH-1:0]   araddr,
  input  logic [2:0]              arprot,
  output logic                    rvalid,
  input  logic                    rready,
  output logic [DATA_WIDTH-1:0]   rdata,
  output logic [1:0]              rresp,
  output logic                    wb_cyc_o,
  output logic                    wb_stb_o,
  output logic                    wb_we_o,
  output logic [ADDR_WIDTH-1:0]   wb_addr_o,
  output logic [DATA_WIDTH-1:0]   wb_data_o,
  output logic [DATA_WIDTH/8-1:0] wb_sel_o,
  input  logic [DATA_WIDTH-1:0]   wb_data_i,
  input  logic                    wb_ack_i
);
  localparam int SW = DATA_WIDTH / 8;
  localparam int CW = TIMEOUT_CYCLES > 0 ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT_CYCLES - 1);
  axil_wb_state_t state, state_n;
  logic aw_rdy, w_rdy, ar_rdy, pref_wr, cyc;
  logic aw_rdy_n, w_rdy_n, ar_rdy_n, pref_wr_n, cyc_n, we_n, bvalid_n, rvalid_n;
  logic [ADDR_WIDTH-1:0] addr_n;
  logic [DATA_WIDTH-1:0] data_n, rdata_n;
  logic [SW-1:0] sel_n;
  logic [1:0] bresp_n, rresp_n;
  logic [CW-1:0] cnt, cnt_n;
  logic contend, aw_hs, w_hs, ar_hs, timeout, unused;
  assign unused = ^{awprot, arprot};
  // Readies are registered; only the arbitration loser is masked combinationally so it sees no handshake.
  assign contend = ar_rdy & arvalid & (awvalid | wvalid);
  assign awready = aw_rdy & ~(contend & ~pref_wr);
  assign wready = w_rdy & ~(contend & ~pref_wr);
  assign arready = ar_rdy & ~(contend & pref_wr);
  assign aw_hs = awvalid & awready;
  assign w_hs = wvalid & wready;
  assign ar_hs = arvalid & arready;
  assign timeout = TIMEOUT_CYCLES != 0 && cnt == TO_LAST;
  assign wb_cyc_o = cyc;
  assign wb_stb_o = cyc;
  always_comb begin
    state_n = state;
    aw_rdy_n = aw_rdy;
    w_rdy_n = w_rdy;
    ar_rdy_n = ar_rdy;
    pref_wr_n = contend ? ~pref_wr : pref_wr;
    cyc_n = 1'b0;
    cnt_n = '0;
    we_n = wb_we_o;
    addr_n = aw_hs ? awaddr : wb_addr_o;
    data_n = w_hs ? wdata : wb_data_o;
    sel_n = w_hs ? wstrb : wb_sel_o;
    bvalid_n = bvalid;
    bresp_n = bresp;
    rvalid_n = rvalid;
    rdata_n = rdata;
    rresp_n = rresp;
    case (state)
      IDLE: begin
        aw_rdy_n = ~ar_hs & ~aw_hs;
        w_rdy_n = ~ar_hs & ~w_hs;
        ar_rdy_n = ~(ar_hs | aw_hs | w_hs);
        if (ar_hs) begin
          we_n = 1'b0;
          addr_n = araddr;
          sel_n = '1;
          state_n = WB_READ;
        end else if (aw_hs | w_hs) begin
          we_n = 1'b1;
          state_n = aw_hs & w_hs ? WB_WRITE : WR_COLLECT;
        end
      end
      WR_COLLECT: begin
        aw_rdy_n = aw_rdy & ~aw_hs;
        w_rdy_n = w_rdy & ~w_hs;
        state_n = aw_hs | w_hs ? WB_WRITE : WR_COLLECT;
      end
      WB_WRITE, WB_READ: begin
        // The first cycle in a WB state only raises cyc/stb; ack is honoured once the slave has seen them.
        if (cyc && (wb_ack_i || timeout)) begin
          if (state == WB_WRITE) begin
            bvalid_n = 1'b1;
            bresp_n = wb_ack_i ? AXI_RESP_OKAY : AXI_RESP_SLVERR;
            state_n = B_RESP;
          end else begin
            rvalid_n = 1'b1;
            rresp_n = wb_ack_i ? AXI_RESP_OKAY : AXI_RESP_SLVERR;
            rdata_n = wb_ack_i ? wb_data_i : '0;
            state_n = R_RESP;
          end
        end else begin
          cyc_n = 1'b1;
          cnt_n = cyc ? cnt + CW'(1) : '0;
        end
      end
      B_RESP: begin
        bvalid_n = ~bready;
        aw_rdy_n = bready;
        w_rdy_n = bready;
        ar_rdy_n = bready;
        state_n = bready ? IDLE : B_RESP;
      end
      R_RESP: begin
        rvalid_n = ~rready;
        aw_rdy_n = rready;
        w_rdy_n = rready;
        ar_rdy_n = rready;
        state_n = rready ? IDLE : R_RESP;
      end
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      aw_rdy <= 1'b0;
      w_rdy <= 1'b0;
      ar_rdy <= 1'b0;
      pref_wr <= 1'b1;
      cyc <= 1'b0;
      cnt <= '0;
      wb_we_o <= 1'b0;
      wb_addr_o <= '0;
      wb_data_o <= '0;
      wb_sel_o <= '0;
      bvalid <= 1'b0;
      bresp <= '0;
      rvalid <= 1'b0;
      rdata <= '0;
      rresp <= '0;
    end else begin
      state <= state_n;
      aw_rdy <= aw_rdy_n;
      w_rdy <= w_rdy_n;
      ar_rdy <= ar_rdy_n;
      pref_wr <= pref_wr_n;
      cyc <= cyc_n;
      cnt <= cnt_n;
      wb_we_o <= we_n;
      wb_addr_o <= addr_n;
      wb_data_o <= data_n;
      wb_sel_o <= sel_n;
      bvalid <= bvalid_n;
      bresp <= bresp_n;
      rvalid <= rvalid_n;
      rdata <= rdata_n;
      rresp <= rresp_n;
    end
  end
endmodule

// File: tb/tb_axil_wb_bridge.sv
// tb_axil_wb_bridge: scoreboard bench for axil_wb_bridge with a programmable Wishbone slave model.
module tb_axil_wb_bridge;
  import axil_wb_pkg::*;
  localparam int TO = 8;
  logic clk = 0, rst = 1;
  logic awvalid = 0, wvalid = 0, bready = 0, arvalid = 0, rready = 0;
  logic awready, wready, bvalid, arready, rvalid;
  logic [31:0] awaddr = 0, wdata = 0, araddr = 0, rdata;
  logic [3:0] wstrb = 0;
  logic [1:0] bresp, rresp;
  logic wb_cyc_o, wb_stb_o, wb_we_o, wb_ack_i;
  logic [31:0] wb_addr_o, wb_data_o, wb_data_i;
  logic [3:0] wb_sel_o;
  always #5 clk = ~clk;
  axil_wb_bridge #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst(rst),
    .awvalid(awvalid), .awready(awready), .awaddr(awaddr), .awprot(3'b000),
    .wvalid(wvalid), .wready(wready), .wdata(wdata), .wstrb(wstrb),
    .bvalid(bvalid), .bready(bready), .bresp(bresp),
    .arvalid(arvalid), .arready(arready), .araddr(araddr), .arprot(3'b000),
    .rvalid(rvalid), .rready(rready), .rdata(rdata), .rresp(rresp),
    .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o), .wb_we_o(wb_we_o),
    .wb_addr_o(wb_addr_o), .wb_data_o(wb_data_o), .wb_sel_o(wb_sel_o),
    .wb_data_i(wb_data_i), .wb_ack_i(wb_ack_i)
  );
  typedef struct packed {logic we; logic [31:0] addr; logic [31:0] data; logic [3:0] sel; logic [7:0] len; logic stable;} wb_t;
  typedef struct packed {logic is_rd; logic [1:0] resp; logic [31:0] data;} rsp_t;
  rsp_t exp_q[$];
  wb_t exp_wb[$];
  wb_t obs[64];
  int nobs = 0, ridx = 0, checks = 0, errors = 0;
  logic ack_en = 1, spur = 0;
  int ack_lat = 0;
  logic [31:0] sdata = 0;
  // Wishbone slave: logs every cycle it sees and acks after ack_lat extra cycles.
  initial begin
    int n;
    n = 0;
    wb_ack_i = 0;
    wb_data_i = 0;
    forever begin
      @(negedge clk);
      wb_data_i = sdata;
      if (wb_cyc_o) begin
        if (n == 0) begin
          obs[nobs].we = wb_we_o;
          obs[nobs].addr = wb_addr_o;
          obs[nobs].data = wb_we_o ? wb_data_o : 32'h0;
          obs[nobs].sel = wb_sel_o;
          obs[nobs].stable = wb_stb_o;
        end else if (wb_stb_o !== 1'b1 || wb_we_o !== obs[nobs].we || wb_addr_o !== obs[nobs].addr ||
                     wb_sel_o !== obs[nobs].sel || (wb_we_o ? wb_data_o : 32'h0) !== obs[nobs].data)
          obs[nobs].stable = 0;
        n++;
        wb_ack_i = ack_en && (n == ack_lat + 1);
      end else begin
        if (n != 0) begin
          obs[nobs].len = 8'(n);
          if (nobs < 63) nobs++;
          n = 0;
        end
        wb_ack_i = spur;
      end
    end
  end
  initial begin
    #400000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end
  task automatic send_aw(input logic [31:0] a);
    awvalid = 1;
    awaddr = a;
    for (int i = 0; i < 60; i++) begin
      #1;
      if (awready) begin
        @(negedge clk);
        awvalid = 0;
        return;
      end
      @(negedge clk);
    end
    checks++; errors++;
    $display("FAIL aw_handshake: awready never seen for addr %h, required within 60 cycles", a);
    awvalid = 0;
  endtask
  task automatic send_w(input logic [31:0] d, input logic [3:0] s);
    wvalid = 1;
    wdata = d;
    wstrb = s;
    for (int i = 0; i < 60; i++) begin
      #1;
      if (wready) begin
        @(negedge clk);
        wvalid = 0;
        return;
      end
      @(negedge clk);
    end
    checks++; errors++;
    $display("FAIL w_handshake: wready never seen for data %h, required within 60 cycles", d);
    wvalid = 0;
  endtask
  task automatic send_ar(input logic [31:0] a);
    arvalid = 1;
    araddr = a;
    for (int i = 0; i < 60; i++) begin
      #1;
      if (arready) begin
        @(negedge clk);
        arvalid = 0;
        return;
      end
      @(negedge clk);
    end
    checks++; errors++;
    $display("FAIL ar_handshake: arready never seen for addr %h, required within 60 cycles", a);
    arvalid = 0;
  endtask
  task automatic wait_r(output rsp_t got, output logic ok);
    ok = 0;
    got = '0;
    for (int i = 0; i < 100; i++) begin
      if (rvalid) begin
        ok = 1;
        got = '{1'b1, rresp, rdata};
        rready = 1;
        @(negedge clk);
        rready = 0;
        return;
      end
      @(negedge clk);
    end
  endtask
  task automatic wait_b(input int hold, output rsp_t got, output logic ok, output logic stable);
    ok = 0;
    stable = 1;
    got = '0;
    for (int i = 0; i < 100; i++) begin
      if (bvalid) begin
        ok = 1;
        got = '{1'b0, bresp, 32'h0};
        for (int h = 0; h < hold; h++) begin
          @(negedge clk);
          if (!bvalid || bresp !== got.resp || awready || wready || arready) stable = 0;
        end
        bready = 1;
        @(negedge clk);
        bready = 0;
        return;
      end
      @(negedge clk);
    end
  endtask
  task automatic test_reset;
    rst = 1;
    repeat (3) @(negedge clk);
    checks++;
    if ({awready, wready, arready, bvalid, rvalid, wb_cyc_o, wb_stb_o, wb_we_o, bresp, rresp} !== 12'h0 ||
        wb_addr_o !== 0 || wb_data_o !== 0 || wb_sel_o !== 0 || rdata !== 0) begin
      errors++;
      $display("FAIL reset_outputs: got rdy=%b%b%b bv=%b rv=%b cyc=%b addr=%h sel=%h, required all zero",
               awready, wready, arready, bvalid, rvalid, wb_cyc_o, wb_addr_o, wb_sel_o);
    end
    rst = 0;
    #1;
    checks++;
    if ({awready, wready, arready} !== 3'b000) begin
      errors++;
      $display("FAIL ready_early: got %b, required 000 before first edge after reset", {awready, wready, arready});
    end
    @(negedge clk);
    checks++;
    if ({awready, wready, arready} !== 3'b111) begin
      errors++;
      $display("FAIL ready_after_reset: got %b, required 111", {awready, wready, arready});
    end
  endtask
  task automatic test_read;
    rsp_t got, e;
    wb_t w, o;
    logic ok;
    ack_en = 1; ack_lat = 3; sdata = 32'hCAFEF00D;
    exp_q.push_back('{1'b1, AXI_RESP_OKAY, 32'hCAFEF00D});
    exp_wb.push_back('{1'b0, 32'h10, 32'h0, 4'hF, 8'd4, 1'b1});
    send_ar(32'h10);
    wait_r(got, ok);
    e = exp_q.pop_front();
    checks++;
    if (!ok || got !== e) begin
      errors++;
      $display("FAIL read_resp: got ok=%b %h, required %h", ok, got, e);
    end
    w = exp_wb.pop_front(); o = obs[ridx]; ridx++;
    checks++;
    if (o !== w || nobs != ridx) begin
      errors++;
      $display("FAIL read_wb: got %h (cycles %0d), required %h (cycles %0d)", o, nobs, w, ridx);
    end
  endtask
  task automatic test_latency;
    rsp_t got, e;
    wb_t w, o;
    logic ok;
    int k;
    ack_lat = 0; sdata = 32'h0BADBEEF;
    exp_q.push_back('{1'b1, AXI_RESP_OKAY, 32'h0BADBEEF});
    exp_wb.push_back('{1'b0, 32'h14, 32'h0, 4'hF, 8'd1, 1'b1});
    send_ar(32'h14);
    k = 0;
    while (!rvalid && k < 20) begin
      @(negedge clk);
      k++;
    end
    checks++;
    if (k != 2) begin
      errors++;
      $display("FAIL read_latency: got %0d cycles to rvalid, required 2", k);
    end
    wait_r(got, ok);
    checks++;
    if (arready !== 1'b1) begin
      errors++;
      $display("FAIL read_turnaround: got arready=%b after R handshake, required 1", arready);
    end
    e = exp_q.pop_front();
    checks++;
    if (!ok || got !== e) begin
      errors++;
      $display("FAIL latency_resp: got ok=%b %h, required %h", ok, got, e);
    end
    w = exp_wb.pop_front(); o = obs[ridx]; ridx++;
    checks++;
    if (o !== w) begin
      errors++;
      $display("FAIL latency_wb: got %h, required %h", o, w);
    end
  endtask
  task automatic test_write_collect;
    rsp_t got, e;
    wb_t w, o;
    logic ok, st;
    ack_lat = 1;
    exp_q.push_back('{1'b0, AXI_RESP_OKAY, 32'h0});
    exp_wb.push_back('{1'b1, 32'h20, 32'h12345678, 4'b0011, 8'd2, 1'b1});
    send_w(32'h12345678, 4'b0011);
    for (int i = 0; i < 2; i++) begin
      if (i != 0) @(negedge clk);
      checks++;
      if ({awready, wready, arready} !== 3'b100) begin
        errors++;
        $display("FAIL collect_ready[%0d]: got %b, required 100", i, {awready, wready, arready});
      end
    end
    send_aw(32'h20);
    wait_b(0, got, ok, st);
    e = exp_q.pop_front();
    checks++;
    if (!ok || got !== e) begin
      errors++;
      $display("FAIL collect_resp: got ok=%b %h, required %h", ok, got, e);
    end
    w = exp_wb.pop_front(); o = obs[ridx]; ridx++;
    checks++;
    if (o !== w || nobs != ridx) begin
      errors++;
      $display("FAIL collect_wb: got %h (cycles %0d), required %h (cycles %0d)", o, nobs, w, ridx);
    end
  endtask
  task automatic test_back_to_back;
    rsp_t g0, g1, e;
    wb_t w, o;
    logic ok0, ok1, st;
    rst = 1;
    @(negedge clk);
    rst = 0;
    @(negedge clk);
    ack_lat = 0; sdata = 32'h5555AAAA;
    exp_q.push_back('{1'b0, AXI_RESP_OKAY, 32'h0});
    exp_q.push_back('{1'b1, AXI_RESP_OKAY, 32'h5555AAAA});
    exp_wb.push_back('{1'b1, 32'h40, 32'hA5A5A5A5, 4'hF, 8'd1, 1'b1});
    exp_wb.push_back('{1'b0, 32'h44, 32'h0, 4'hF, 8'd1, 1'b1});
    fork
      send_aw(32'h40);
      send_w(32'hA5A5A5A5, 4'hF);
      send_ar(32'h44);
      begin wait_b(0, g0, ok0, st); wait_r(g1, ok1); end
    join
    e = exp_q.pop_front();
    checks++;
    if (!ok0 || g0 !== e) begin errors++; $display("FAIL arb1_first: got ok=%b %h, required %h", ok0, g0, e); end
    e = exp_q.pop_front();
    checks++;
    if (!ok1 || g1 !== e) begin errors++; $display("FAIL arb1_second: got ok=%b %h, required %h", ok1, g1, e); end
    sdata = 32'h3C3C3C3C;
    exp_q.push_back('{1'b1, AXI_RESP_OKAY, 32'h3C3C3C3C});
    exp_q.push_back('{1'b0, AXI_RESP_OKAY, 32'h0});
    exp_wb.push_back('{1'b0, 32'h48, 32'h0, 4'hF, 8'd1, 1'b1});
    exp_wb.push_back('{1'b1, 32'h4C, 32'h0F0F0F0F, 4'hC, 8'd1, 1'b1});
    fork
      send_aw(32'h4C);
      send_w(32'h0F0F0F0F, 4'hC);
      send_ar(32'h48);
      begin wait_r(g0, ok0); wait_b(0, g1, ok1, st); end
    join
    e = exp_q.pop_front();
    checks++;
    if (!ok0 || g0 !== e) begin errors++; $display("FAIL arb2_first: got ok=%b %h, required %h", ok0, g0, e); end
    e = exp_q.pop_front();
    checks++;
    if (!ok1 || g1 !== e) begin errors++; $display("FAIL arb2_second: got ok=%b %h, required %h", ok1, g1, e); end
    for (int i = 0; i < 4; i++) begin
      w = exp_wb.pop_front(); o = obs[ridx]; ridx++;
      checks++;
      if (o !== w) begin
        errors++;
        $display("FAIL arb_wb[%0d]: got %h, required %h", i, o, w);
      end
    end
  endtask
  task automatic test_timeout;
    rsp_t got, e;
    wb_t w, o;
    logic ok, st;
    ack_en = 0; sdata = 32'hDEADBEEF;
    exp_q.push_back('{1'b1, AXI_RESP_SLVERR, 32'h0});
    exp_wb.push_back('{1'b0, 32'h80, 32'h0, 4'hF, 8'(TO), 1'b1});
    send_ar(32'h80);
    wait_r(got, ok);
    e = exp_q.pop_front();
    checks++;
    if (!ok || got !== e) begin errors++; $display("FAIL timeout_read: got ok=%b %h, required %h", ok, got, e); end
    exp_q.push_back('{1'b0, AXI_RESP_SLVERR, 32'h0});
    exp_wb.push_back('{1'b1, 32'h84, 32'h11223344, 4'hF, 8'(TO), 1'b1});
    fork
      send_aw(32'h84);
      send_w(32'h11223344, 4'hF);
    join
    wait_b(0, got, ok, st);
    e = exp_q.pop_front();
    checks++;
    if (!ok || got !== e) begin errors++; $display("FAIL timeout_write: got ok=%b %h, required %h", ok, got, e); end
    for (int i = 0; i < 2; i++) begin
      w = exp_wb.pop_front(); o = obs[ridx]; ridx++;
      checks++;
      if (o !== w) begin
        errors++;
        $display("FAIL timeout_wb[%0d]: got %h, required %h", i, o, w);
      end
    end
    ack_en = 1;
  endtask
  task automatic test_bready_hold;
    rsp_t got, e;
    wb_t w, o;
    logic ok, st;
    ack_lat = 0;
    exp_q.push_back('{1'b0, AXI_RESP_OKAY, 32'h0});
    exp_wb.push_back('{1'b1, 32'h90, 32'hFEEDFACE, 4'hF, 8'd1, 1'b1});
    fork
      send_aw(32'h90);
      send_w(32'hFEEDFACE, 4'hF);
    join
    wait_b(5, got, ok, st);
    e = exp_q.pop_front();
    checks++;
    if (!ok || got !== e || st !== 1'b1) begin
      errors++;
      $display("FAIL bready_hold: got ok=%b stable=%b %h, required stable=1 %h", ok, st, got, e);
    end
    checks++;
    if ({awready, wready, arready} !== 3'b111) begin
      errors++;
      $display("FAIL ready_after_b: got %b, required 111", {awready, wready, arready});
    end
    w = exp_wb.pop_front(); o = obs[ridx]; ridx++;
    checks++;
    if (o !== w) begin errors++; $display("FAIL bready_wb: got %h, required %h", o, w); end
  endtask
  task automatic test_reset_mid;
    rsp_t got, e;
    wb_t w, o;
    logic ok;
    ack_en = 0;
    send_ar(32'hA0);
    @(negedge clk);
    checks++;
    if (wb_cyc_o !== 1'b1) begin errors++; $display("FAIL abort_setup: got cyc=%b, required 1", wb_cyc_o); end
    rst = 1;
    #1;
    checks++;
    if ({wb_cyc_o, wb_stb_o, rvalid, bvalid, awready, wready, arready} !== 7'h0) begin
      errors++;
      $display("FAIL abort_outputs: got cyc=%b stb=%b rv=%b bv=%b rdy=%b%b%b, required all 0",
               wb_cyc_o, wb_stb_o, rvalid, bvalid, awready, wready, arready);
    end
    @(negedge clk);
    rst = 0;
    @(negedge clk);
    ridx = nobs;
    spur = 1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (rvalid || bvalid || wb_cyc_o || arready !== 1'b1) begin
        errors++;
        $display("FAIL spurious_ack[%0d]: got rv=%b bv=%b cyc=%b arready=%b, required 0 0 0 1", i, rvalid, bvalid, wb_cyc_o, arready);
      end
    end
    spur = 0; ack_en = 1; ack_lat = 2; sdata = 32'h600DF00D;
    exp_q.push_back('{1'b1, AXI_RESP_OKAY, 32'h600DF00D});
    exp_wb.push_back('{1'b0, 32'hB0, 32'h0, 4'hF, 8'd3, 1'b1});
    send_ar(32'hB0);
    wait_r(got, ok);
    e = exp_q.pop_front();
    checks++;
    if (!ok || got !== e) begin errors++; $display("FAIL after_abort_read: got ok=%b %h, required %h", ok, got, e); end
    w = exp_wb.pop_front(); o = obs[ridx]; ridx++;
    checks++;
    if (o !== w || nobs != ridx) begin
      errors++;
      $display("FAIL after_abort_wb: got %h (cycles %0d), required %h (cycles %0d)", o, nobs, w, ridx);
    end
  endtask
  initial begin
    @(negedge clk);
    test_reset();
    test_read();
    test_latency();
    test_write_collect();
    test_back_to_back();
    test_timeout();
    test_bready_hold();
    test_reset_mid();
    repeat (3) @(negedge clk);
    checks++;
    if (exp_q.size() != 0 || rvalid || bvalid) begin
      errors++;
      $display("FAIL final_idle: got %0d pending expectations rv=%b bv=%b, required 0 0 0", exp_q.size(), rvalid, bvalid);
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
